multicycle_maindec: RTL and testbench

Moore-style main control FSM for the multicycle MIPS core, successor to the single-cycle opcode decoder. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the shared ALU, instruction register, PC-enable and register-file controls. Adds a parametrised memory wait-state counter, sub-word load flags, BNE support and illegal-opcode reporting.

---
 rtl/multicycle_maindec.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_maindec.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_maindec.sv
// Moore main control FSM for the multicycle MIPS core: fetch/decode/execute/memory/writeback
// sequencing with a MEM_WAIT-cycle hold on every memory state and illegal-opcode pulse.
module multicycle_maindec #(
  parameter int MEM_WAIT = 0,
  parameter int ALUOP_W  = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         op,
  output logic               pcwrite,
  output logic               branch,
  output logic               ne,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [2:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               half,
  output logic               b,
  output logic               lbu,
  output logic               illegal,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wait_done;

  // Counter only ever moves inside a memory state, so it never exceeds WAIT_LAST.
  assign wait_done = (cnt_q == WAIT_LAST);
  assign state     = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    ne       = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 3'b000;
    pcsrc    = 2'b00;
    aluop    = ALU_ADD;
    half     = 1'b0;
    b        = 1'b0;
    lbu      = 1'b0;
    illegal  = 1'b0;

    case (state_q)
      S_FETCH: begin
        alusrcb = 3'b001;
        if (wait_done) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DECODE: begin
        // Speculative branch target PC + (signimm << 2) lands in ALUOut.
        alusrcb = 3'b011;
        case (op)
          OP_LW, OP_LH, OP_LB, OP_LBU, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:                           state_d = S_EXEC;
          OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
          OP_ADDI, OP_ORI:                    state_d = S_IEXEC;
          OP_J:                               state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 3'b010;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (wait_done) state_d = S_MEMWB;
        else           cnt_d   = cnt_q + 4'd1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        half     = (op == OP_LH) || (op == OP_LB);
        b        = (op == OP_LB);
        lbu      = (op == OP_LBU);
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        // Strobe only on the final wait cycle so each store writes exactly once.
        iord = 1'b1;
        if (wait_done) begin
          memwrite = 1'b1;
          state_d  = S_FETCH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = ALU_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALU_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        ne      = (op == OP_BNE);
        state_d = S_FETCH;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        if (op == OP_ORI) begin
          alusrcb = 3'b100;
          aluop   = ALU_OR;
        end else begin
          alusrcb = 3'b010;
        end
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_maindec.sv
// Bench for multicycle_maindec: two instances (MEM_WAIT 0 and 2) checked cycle by cycle
// against per-instruction control traces built from the instruction-class rules.
module tb_multicycle_maindec;

  typedef struct packed {
    logic [3:0] state;
    logic       pcwrite;
    logic       branch;
    logic       ne;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       half;
    logic       b;
    logic       lbu;
    logic       illegal;
  } ctl_t;

  localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LB = 6'b100000, LBU = 6'b100100;
  localparam logic [5:0] SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, JMP = 6'b000010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst2;
  logic [5:0] op0, op2;
  wire ctl_t  obs0, obs2;

  int   nerr = 0;
  int   nchk = 0;
  ctl_t exp_q[$];
  logic [5:0] legal_ops [0:10] = '{LW, LH, LB, LBU, SW, RT, BEQ, BNE, ADDI, ORI, JMP};

  multicycle_maindec #(.MEM_WAIT(0), .ALUOP_W(3)) u_w0 (
    .clk(clk), .reset_n(rst0), .op(op0),
    .pcwrite(obs0.pcwrite), .branch(obs0.branch), .ne(obs0.ne), .iord(obs0.iord),
    .memwrite(obs0.memwrite), .irwrite(obs0.irwrite), .regdst(obs0.regdst),
    .memtoreg(obs0.memtoreg), .regwrite(obs0.regwrite), .alusrca(obs0.alusrca),
    .alusrcb(obs0.alusrcb), .pcsrc(obs0.pcsrc), .aluop(obs0.aluop), .half(obs0.half),
    .b(obs0.b), .lbu(obs0.lbu), .illegal(obs0.illegal), .state(obs0.state)
  );

  multicycle_maindec #(.MEM_WAIT(2), .ALUOP_W(3)) u_w2 (
    .clk(clk), .reset_n(rst2), .op(op2),
    .pcwrite(obs2.pcwrite), .branch(obs2.branch), .ne(obs2.ne), .iord(obs2.iord),
    .memwrite(obs2.memwrite), .irwrite(obs2.irwrite), .regdst(obs2.regdst),
    .memtoreg(obs2.memtoreg), .regwrite(obs2.regwrite), .alusrca(obs2.alusrca),
    .alusrcb(obs2.alusrcb), .pcsrc(obs2.pcsrc), .aluop(obs2.aluop), .half(obs2.half),
    .b(obs2.b), .lbu(obs2.lbu), .illegal(obs2.illegal), .state(obs2.state)
  );

  function automatic ctl_t blank(input logic [3:0] s);
    ctl_t c = '0;
    c.state = s;
    return c;
  endfunction

  function automatic ctl_t fetch_cyc(input bit last);
    ctl_t c = blank(4'd0);
    c.alusrcb = 3'b001;
    c.irwrite = last;
    c.pcwrite = last;
    return c;
  endfunction

  // Expected control vector for every cycle of one instruction, from the class rules.
  task automatic build_trace(input int w, input logic [5:0] o);
    ctl_t c;
    bit   is_load, is_mem, known;
    is_load = (o == LW) || (o == LH) || (o == LB) || (o == LBU);
    is_mem  = is_load || (o == SW);
    known   = is_mem || (o == RT) || (o == BEQ) || (o == BNE) || (o == ADDI) ||
              (o == ORI) || (o == JMP);
    for (int i = 0; i <= w; i++) exp_q.push_back(fetch_cyc(i == w));
    c = blank(4'd1); c.alusrcb = 3'b011; c.illegal = !known;
    exp_q.push_back(c);
    if (is_mem) begin
      c = blank(4'd2); c.alusrca = 1'b1; c.alusrcb = 3'b010;
      exp_q.push_back(c);
      for (int i = 0; i <= w; i++) begin
        c = blank(is_load ? 4'd3 : 4'd5);
        c.iord = 1'b1;
        c.memwrite = !is_load && (i == w);
        exp_q.push_back(c);
      end
      if (is_load) begin
        c = blank(4'd4); c.regwrite = 1'b1; c.memtoreg = 1'b1;
        c.half = (o == LH) || (o == LB); c.b = (o == LB); c.lbu = (o == LBU);
        exp_q.push_back(c);
      end
    end else if (o == RT) begin
      c = blank(4'd6); c.alusrca = 1'b1; c.aluop = 3'b010;
      exp_q.push_back(c);
      c = blank(4'd7); c.regwrite = 1'b1; c.regdst = 1'b1;
      exp_q.push_back(c);
    end else if (o == BEQ || o == BNE) begin
      c = blank(4'd8); c.alusrca = 1'b1; c.aluop = 3'b001; c.pcsrc = 2'b01;
      c.branch = 1'b1; c.ne = (o == BNE);
      exp_q.push_back(c);
    end else if (o == ADDI || o == ORI) begin
      c = blank(4'd9); c.alusrca = 1'b1;
      c.alusrcb = (o == ORI) ? 3'b100 : 3'b010;
      c.aluop   = (o == ORI) ? 3'b011 : 3'b000;
      exp_q.push_back(c);
      c = blank(4'd10); c.regwrite = 1'b1;
      exp_q.push_back(c);
    end else if (o == JMP) begin
      c = blank(4'd11); c.pcsrc = 2'b10; c.pcwrite = 1'b1;
      exp_q.push_back(c);
    end
  endtask

  task automatic check(input string tag, input ctl_t got, input ctl_t want);
    nchk++;
    assert (got === want) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Called just after a falling edge with the DUT at the start of FETCH.
  // ncyc < 0 runs the whole instruction; otherwise stops after ncyc checked cycles.
  task automatic run_instr(input bit w2, input logic [5:0] o, input int ncyc);
    ctl_t want;
    int   n = 0;
    build_trace(w2 ? 2 : 0, o);
    if (w2) op2 = o; else op0 = o;
    while (exp_q.size() > 0 && (ncyc < 0 || n < ncyc)) begin
      want = exp_q.pop_front();
      #1;
      check($sformatf("w%0d op=%b cyc%0d", w2 ? 2 : 0, o, n), w2 ? obs2 : obs0, want);
      n++;
      @(posedge clk);
      @(negedge clk);
    end
    exp_q.delete();
  endtask

  function automatic logic [5:0] pick_op();
    if ($urandom_range(0, 5) == 0) return 6'($urandom);
    return legal_ops[$urandom_range(0, 10)];
  endfunction

  initial begin
    ctl_t c;
    rst0 = 1'b1; rst2 = 1'b1; op0 = '0; op2 = '0;
    #1 rst0 = 1'b0; rst2 = 1'b0;
    #1;
    check("reset w0", obs0, fetch_cyc(1'b1));
    check("reset w2", obs2, fetch_cyc(1'b0));
    @(negedge clk);
    rst0 = 1'b1;

    run_instr(1'b0, LW, -1);
    run_instr(1'b0, BNE, -1);
    run_instr(1'b0, BEQ, -1);
    run_instr(1'b0, ORI, -1);
    run_instr(1'b0, ADDI, -1);
    run_instr(1'b0, 6'b111111, -1);
    run_instr(1'b0, LB, -1);
    run_instr(1'b0, JMP, -1);
    run_instr(1'b0, LBU, -1);
    run_instr(1'b0, LH, -1);
    run_instr(1'b0, SW, -1);
    run_instr(1'b0, RT, -1);

    // Reset asserted while in EXEC, then released into a fresh fetch.
    run_instr(1'b0, RT, 2);
    #1;
    c = blank(4'd6); c.alusrca = 1'b1; c.aluop = 3'b010;
    check("w0 in exec", obs0, c);
    rst0 = 1'b0;
    #1 check("w0 reset mid-exec", obs0, fetch_cyc(1'b1));
    @(negedge clk);
    #1 check("w0 held in reset", obs0, fetch_cyc(1'b1));
    rst0 = 1'b1;
    run_instr(1'b0, LW, -1);

    for (int i = 0; i < 40; i++) run_instr(1'b0, pick_op(), -1);
    rst0 = 1'b0;

    rst2 = 1'b1;
    run_instr(1'b1, SW, -1);
    run_instr(1'b1, LW, -1);
    run_instr(1'b1, BNE, -1);
    run_instr(1'b1, ORI, -1);
    run_instr(1'b1, 6'b111111, -1);
    run_instr(1'b1, LB, -1);
    run_instr(1'b1, RT, -1);
    run_instr(1'b1, JMP, -1);

    // Reset asserted on the second MEMRD wait cycle must also clear the wait counter.
    run_instr(1'b1, LW, 6);
    #1;
    c = blank(4'd3); c.iord = 1'b1;
    check("w2 in memrd", obs2, c);
    rst2 = 1'b0;
    #1 check("w2 reset mid-wait", obs2, fetch_cyc(1'b0));
    @(negedge clk);
    #1 check("w2 held in reset", obs2, fetch_cyc(1'b0));
    rst2 = 1'b1;
    run_instr(1'b1, SW, -1);

    for (int i = 0; i < 30; i++) run_instr(1'b1, pick_op(), -1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
